// File: rtl/mac8_seq_ctrl.sv
// mac8_seq_ctrl: sequences operand byte pairs into a MAC8 datapath, waits out the
// datapath latency and presents the accumulated result on a valid/ready handshake.
module mac8_seq_ctrl #(
  parameter int MAC_LAT = 1,
  parameter int LEN_W   = 4
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic             cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [7:0]       mac_acc,
  output logic             res_valid,
  output logic [7:0]       res_data,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    FIRE   = 3'd4,
    WAIT   = 3'd5,
    RESULT = 3'd6
  } state_t;

  // WAIT counts down from MAC_LAT-1 to zero, so it lasts exactly MAC_LAT cycles.
  localparam logic [2:0] WAIT_INIT = 3'(MAC_LAT - 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             in_ready_q, in_ready_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clr_q, mac_clr_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  // Next-state, counter and data-capture logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          cnt_d   = cmd_len;
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        wcnt_d = WAIT_INIT;
        if (cnt_q == {LEN_W{1'b0}}) begin
          state_d = WAIT;
        end else begin
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_data;
          state_d = LOAD_B;
        end else begin
          state_d = LOAD_A;
        end
      end
      LOAD_B: begin
        if (in_valid && in_ready_q) begin
          b_d     = in_data;
          state_d = FIRE;
        end else begin
          state_d = LOAD_B;
        end
      end
      FIRE: begin
        cnt_d  = cnt_q - LEN_W'(1'b1);
        wcnt_d = WAIT_INIT;
        if (cnt_q == LEN_W'(1'b1)) begin
          state_d = WAIT;
        end else begin
          state_d = LOAD_A;
        end
      end
      WAIT: begin
        if (wcnt_q == 3'd0) begin
          res_data_d = mac_acc;
          state_d    = RESULT;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
    mac_en_d    = (state_d == FIRE);
    mac_clr_d   = (state_d == CLEAR);
    res_valid_d = (state_d == RESULT);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath registers and registered outputs.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q     <= IDLE;
      cnt_q       <= {LEN_W{1'b0}};
      wcnt_q      <= 3'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      res_data_q  <= 8'd0;
      in_ready_q  <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      in_ready_q  <= in_ready_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac8_seq_ctrl.sv
// Testbench for mac8_seq_ctrl: behavioural MAC8 datapath plus a sum-of-products
// reference model, driven by directed scenarios and randomized sequences.
module tb_mac8_seq_ctrl;
  localparam int MAC_LAT = 1;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_start, in_valid, in_ready, mac_en, mac_clr;
  logic             res_valid, res_ready, busy;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       in_data, mac_a, mac_b, mac_acc, res_data;
  logic [7:0]       acc_m;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus controls
  logic [7:0] stim[$];
  int stall_idx, stall_n, ready_delay;
  bit rand_valid, rand_ready, start_in_result;

  // observations collected by run_seq
  logic [7:0] obs_a[$], obs_b[$];
  int en_cyc[$], acc_cyc[$];
  int n_clr, clr_cyc, n_rdy, first_rv, rv_cycles, viol, stall_total, n_consumed;
  logic [7:0] rdata;
  bit unstable, rv_dropped, timeout;
  logic busy_after, busy_after2, rv_after;

  mac8_seq_ctrl #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .SYS_CLK(clk), .SYS_RST(rst), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_acc(mac_acc), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // MAC8 datapath model with one cycle of latency
  always @(posedge clk or posedge rst) begin
    if (rst) acc_m <= 8'd0;
    else if (mac_clr) acc_m <= 8'd0;
    else if (mac_en) acc_m <= 8'(acc_m + mac_a * mac_b);
  end
  assign mac_acc = acc_m;

  function automatic logic [7:0] ref_result();
    int s = 0;
    for (int i = 0; i < stim.size() / 2; i++) s += int'(stim[2*i]) * int'(stim[2*i+1]);
    return 8'(s % 256);
  endfunction

  task automatic set_modes();
    stall_idx = -1; stall_n = 0; ready_delay = 0;
    rand_valid = 1'b0; rand_ready = 1'b0; start_in_result = 1'b0;
  endtask

  // Runs one command of length len, feeding stim[] and recording DUT behaviour per cycle.
  task automatic run_seq(input int len);
    int cyc, idx, stalled, post;
    bit hs_done;
    obs_a.delete(); obs_b.delete(); en_cyc.delete(); acc_cyc.delete();
    n_clr = 0; clr_cyc = -1; n_rdy = 0; first_rv = -1; rv_cycles = 0; viol = 0;
    stall_total = 0; rdata = 8'd0; unstable = 1'b0; rv_dropped = 1'b0; timeout = 1'b0;
    busy_after = 1'b1; busy_after2 = 1'b1; rv_after = 1'b1;
    cyc = 0; idx = 0; stalled = 0; post = 0; hs_done = 1'b0;
    @(negedge clk);
    cmd_start = 1'b1; cmd_len = len[LEN_W-1:0];
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      cyc++;
      cmd_start = 1'b0;
      if (cyc > 400) begin timeout = 1'b1; break; end
      if (mac_en) begin obs_a.push_back(mac_a); obs_b.push_back(mac_b); en_cyc.push_back(cyc); end
      if (mac_clr) begin n_clr++; clr_cyc = cyc; end
      if (in_ready) n_rdy++;
      if (mac_en && mac_clr) viol++;
      if ((mac_en || mac_clr) && (res_valid || !busy)) viol++;
      if (hs_done) begin
        res_ready = 1'b0; post++;
        in_valid = 1'b1; in_data = 8'($urandom);
        if (post == 1) begin busy_after = busy; rv_after = res_valid; end
        else begin busy_after2 = busy; break; end
        continue;
      end
      if (res_valid) begin
        rv_cycles++;
        if (first_rv < 0) begin
          first_rv = cyc; rdata = res_data;
          if (start_in_result) begin cmd_start = 1'b1; cmd_len = LEN_W'($urandom_range(1, 15)); end
        end else if (res_data !== rdata) unstable = 1'b1;
        res_ready = (rv_cycles > ready_delay);
        if (res_ready) hs_done = 1'b1;
      end else begin
        if (first_rv >= 0) rv_dropped = 1'b1;
        res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (in_ready) begin
        if (idx == stall_idx && stalled < stall_n) begin
          in_valid = 1'b0; in_data = 8'($urandom); stalled++; stall_total++;
        end else if (rand_valid && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_data = 8'($urandom); stall_total++;
        end else if (idx < stim.size()) begin
          in_valid = 1'b1; in_data = stim[idx]; acc_cyc.push_back(cyc); idx++;
        end else begin
          in_valid = 1'b0; idx++;
        end
      end else begin
        in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data = 8'($urandom);
      end
    end
    n_consumed = idx;
    in_valid = 1'b0; res_ready = 1'b0; cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({in_ready, mac_en, mac_clr, res_valid, busy, mac_a, mac_b, res_data} !== 29'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b,%b,%b,%b,%b,%h,%h,%h want all 0",
               in_ready, mac_en, mac_clr, res_valid, busy, mac_a, mac_b, res_data);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    set_modes();
    stim = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd7};
    run_seq(3);
    n_checks++;
    if (timeout) begin n_errors++; $display("FAIL basic_timeout: got timeout want result"); end
    n_checks++;
    if (obs_a.size() !== 3) begin n_errors++; $display("FAIL basic_en_count: got %0d want 3", obs_a.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_a[i] !== stim[2*i] || obs_b[i] !== stim[2*i+1]) begin
        n_errors++;
        $display("FAIL basic_pair%0d: got (%0d,%0d) want (%0d,%0d)", i, obs_a[i], obs_b[i], stim[2*i], stim[2*i+1]);
      end
    end
    n_checks++;
    if (rdata !== ref_result() || rdata !== 8'h21) begin n_errors++; $display("FAIL basic_res_data: got %h want 21", rdata); end
    n_checks++;
    if (first_rv !== 3*3 + MAC_LAT + 2) begin n_errors++; $display("FAIL basic_latency: got %0d want %0d", first_rv, 3*3 + MAC_LAT + 2); end
    n_checks++;
    if (n_clr !== 1 || clr_cyc !== 1) begin n_errors++; $display("FAIL basic_clr: got %0d pulses at %0d want 1 at 1", n_clr, clr_cyc); end
    n_checks++;
    if (viol !== 0) begin n_errors++; $display("FAIL basic_strobe_rules: got %0d violations want 0", viol); end
  endtask

  task automatic test_stall();
    set_modes();
    stall_idx = 1; stall_n = 5;
    stim = '{8'd10, 8'd9};
    run_seq(1);
    n_checks++;
    if (en_cyc.size() !== 1 || acc_cyc.size() !== 2) begin
      n_errors++; $display("FAIL stall_counts: got %0d en %0d bytes want 1 en 2 bytes", en_cyc.size(), acc_cyc.size());
    end else begin
      n_checks++;
      if (en_cyc[0] !== acc_cyc[1] + 1) begin n_errors++; $display("FAIL stall_en_timing: got cycle %0d want %0d", en_cyc[0], acc_cyc[1] + 1); end
    end
    n_checks++;
    if (rdata !== 8'h5A) begin n_errors++; $display("FAIL stall_res_data: got %h want 5a", rdata); end
    n_checks++;
    if (first_rv !== 3 + MAC_LAT + 2 + 5) begin n_errors++; $display("FAIL stall_latency: got %0d want %0d", first_rv, 3 + MAC_LAT + 2 + 5); end
  endtask

  task automatic test_wrap();
    set_modes();
    stim = '{8'd255, 8'd255, 8'd1, 8'd1};
    run_seq(2);
    n_checks++;
    if (rdata !== 8'h02) begin n_errors++; $display("FAIL wrap_res_data: got %h want 02", rdata); end
    n_checks++;
    if (first_rv !== 3*2 + MAC_LAT + 2) begin n_errors++; $display("FAIL wrap_latency: got %0d want %0d", first_rv, 3*2 + MAC_LAT + 2); end
  endtask

  task automatic test_zero();
    set_modes();
    stim.delete();
    run_seq(0);
    n_checks++;
    if (n_clr !== 1 || obs_a.size() !== 0) begin n_errors++; $display("FAIL zero_strobes: got %0d clr %0d en want 1 clr 0 en", n_clr, obs_a.size()); end
    n_checks++;
    if (n_rdy !== 0 || n_consumed !== 0) begin n_errors++; $display("FAIL zero_in_ready: got %0d ready cycles %0d bytes want 0", n_rdy, n_consumed); end
    n_checks++;
    if (first_rv !== 3 || rdata !== 8'h00) begin n_errors++; $display("FAIL zero_result: got cycle %0d data %h want cycle 3 data 00", first_rv, rdata); end
  endtask

  task automatic test_backpressure();
    set_modes();
    ready_delay = 4; start_in_result = 1'b1;
    stim = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_seq(2);
    n_checks++;
    if (unstable || rv_dropped) begin n_errors++; $display("FAIL bp_stable: got unstable=%0d dropped=%0d want 0,0", unstable, rv_dropped); end
    n_checks++;
    if (rv_cycles !== ready_delay + 1) begin n_errors++; $display("FAIL bp_valid_cycles: got %0d want %0d", rv_cycles, ready_delay + 1); end
    n_checks++;
    if (rdata !== ref_result()) begin n_errors++; $display("FAIL bp_res_data: got %h want %h", rdata, ref_result()); end
    n_checks++;
    if (busy_after !== 1'b0 || rv_after !== 1'b0) begin n_errors++; $display("FAIL bp_busy_drop: got busy=%b valid=%b want 0,0", busy_after, rv_after); end
    n_checks++;
    if (busy_after2 !== 1'b0) begin n_errors++; $display("FAIL bp_start_ignored: got busy=%b want 0", busy_after2); end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    bit found = 1'b0;
    set_modes();
    stim = '{8'd7, 8'd8, 8'd6, 8'd5};
    @(negedge clk); cmd_start = 1'b1; cmd_len = LEN_W'(2);
    @(posedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cmd_start = 1'b0;
      if (in_ready && idx == 3) begin found = 1'b1; break; end
      in_valid = 1'b1;
      if (in_ready) begin in_data = stim[idx]; idx++; end
      else in_data = 8'($urandom);
    end
    in_valid = 1'b0;
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL rstmid_reach_load_b: got timeout want LOAD_B of pair 2"); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, mac_en, mac_clr, res_valid, busy, mac_a, mac_b, res_data} !== 29'd0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got %b,%b,%b,%b,%b,%h,%h,%h want all 0",
               in_ready, mac_en, mac_clr, res_valid, busy, mac_a, mac_b, res_data);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_abandon: got busy=%b valid=%b want 0,0", busy, res_valid); end
    stim = '{8'd3, 8'd3};
    run_seq(1);
    n_checks++;
    if (rdata !== 8'h09 || first_rv !== 3 + MAC_LAT + 2) begin
      n_errors++; $display("FAIL rstmid_restart: got data %h cycle %0d want 09 cycle %0d", rdata, first_rv, 3 + MAC_LAT + 2);
    end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 8; it++) begin
      set_modes();
      rand_valid = 1'b1; rand_ready = 1'b1; ready_delay = $urandom_range(0, 3);
      len = (it == 0) ? 15 : $urandom_range(0, 15);
      stim.delete();
      for (int i = 0; i < 2*len; i++) stim.push_back(8'($urandom));
      run_seq(len);
      n_checks++;
      if (timeout || obs_a.size() !== len || n_consumed !== 2*len) begin
        n_errors++; $display("FAIL rand%0d_counts: got timeout=%0d en=%0d bytes=%0d want 0,%0d,%0d", it, timeout, obs_a.size(), n_consumed, len, 2*len);
      end else begin
        for (int i = 0; i < len; i++) begin
          n_checks++;
          if (obs_a[i] !== stim[2*i] || obs_b[i] !== stim[2*i+1]) begin
            n_errors++; $display("FAIL rand%0d_pair%0d: got (%h,%h) want (%h,%h)", it, i, obs_a[i], obs_b[i], stim[2*i], stim[2*i+1]);
          end
        end
      end
      n_checks++;
      if (rdata !== ref_result()) begin n_errors++; $display("FAIL rand%0d_res_data: got %h want %h", it, rdata, ref_result()); end
      n_checks++;
      if (first_rv !== 3*len + MAC_LAT + 2 + stall_total) begin
        n_errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, first_rv, 3*len + MAC_LAT + 2 + stall_total);
      end
      n_checks++;
      if (viol !== 0 || n_clr !== 1 || unstable) begin
        n_errors++; $display("FAIL rand%0d_strobes: got viol=%0d clr=%0d unstable=%0d want 0,1,0", it, viol, n_clr, unstable);
      end
    end
  endtask

  initial begin
    cmd_start = 1'b0; cmd_len = '0; in_valid = 1'b0; in_data = 8'd0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac8_seq_ctrl.md
MAC8_SEQ_CTRL -- requirements
Module: mac8_seq_ctrl

Interface
REQ-001 Parameters SHALL be:
- MAC_LAT, default 1: cycles from the mac_en pulse to mac_acc being valid; legal range 1-7.
- LEN_W, default 4: width of cmd_len.
REQ-002 The block SHALL use one clock, SYS_CLK, and a single asynchronous, active-high reset, SYS_RST.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- SYS_CLK  in  1  clock, rising edge.
- SYS_RST  in  1  async reset, active-high.
- cmd_start  in  1  one-cycle request to run a sequence.
- cmd_len  in  LEN_W  number of operand pairs in the sequence.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  operand byte; A and B alternate, A first.
- in_ready  out  1  controller accepts in_data this cycle.
- mac_a  out  8  A operand to the MAC8 datapath.
- mac_b  out  8  B operand to the MAC8 datapath.
- mac_en  out  1  one-cycle multiply-accumulate strobe.
- mac_clr  out  1  one-cycle accumulator clear strobe.
- mac_acc  in  8  accumulator value from the MAC8 datapath.
- res_valid  out  1  result available.
- res_data  out  8  captured accumulator result.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 The FSM states SHALL be IDLE, CLEAR, LOAD_A, LOAD_B, FIRE, WAIT and RESULT, with a single registered state variable.
REQ-005 In IDLE, cmd_start=1 SHALL latch cmd_len into the remaining-pairs counter cnt and move to CLEAR; cmd_start in any other state SHALL be ignored.
REQ-006 CLEAR SHALL assert mac_clr for exactly one cycle, then go to WAIT if cnt==0, else to LOAD_A.
REQ-007 LOAD_A SHALL assert in_ready; on in_valid&in_ready it SHALL capture in_data into a_reg and go to LOAD_B; otherwise it SHALL hold.
REQ-008 LOAD_B SHALL assert in_ready; on in_valid&in_ready it SHALL capture in_data into b_reg and go to FIRE; otherwise it SHALL hold.
REQ-009 in_ready SHALL be 0 in every state other than LOAD_A and LOAD_B, and in_data SHALL NOT be consumed in those states.
REQ-010 mac_a and mac_b SHALL be driven continuously from a_reg and b_reg, stable throughout FIRE.
REQ-011 FIRE SHALL assert mac_en for exactly one cycle and decrement cnt, then go to WAIT if the decremented cnt==0, else to LOAD_A.
REQ-012 WAIT SHALL last exactly MAC_LAT cycles, then capture mac_acc into res_data and go to RESULT.
REQ-013 RESULT SHALL assert res_valid with res_data held stable; on res_ready=1 it SHALL go to IDLE; otherwise it SHALL hold.
REQ-014 Accumulation width and overflow are owned by the datapath (modulo 256); the controller SHALL pass mac_acc through unmodified.
REQ-015 With in_valid held at 1, res_valid SHALL first assert 3*cmd_len + MAC_LAT + 2 cycles after the edge that samples cmd_start.
REQ-016 mac_en and mac_clr SHALL never be asserted in the same cycle, and neither SHALL be asserted in IDLE or RESULT.
REQ-017 cmd_len=0 SHALL produce a clear, WAIT, and then a result equal to mac_acc after the clear (0), with no bytes consumed.

Reset
REQ-018 While SYS_RST=1, the block SHALL asynchronously force:
- state=IDLE and cnt=0;
- a_reg, b_reg and res_data to 0;
- every output to 0.
REQ-019 Reset asserted in any state, including mid-sequence, SHALL abandon the sequence without a result; after SYS_RST is released, the first cmd_start SHALL be accepted normally.

Verification
REQ-020 The bench SHALL cover these directed scenarios (MAC_LAT=1, behavioural MAC8 model):
- Basic sequence: cmd_len=3, bytes 2,3,4,5,1,7 with in_valid held high -> three mac_en pulses with (a,b)=(2,3),(4,5),(1,7); res_data=0x21; res_valid at cycle 12 after start.
- Input stall: cmd_len=1, in_valid low for 5 cycles in LOAD_B, then byte B=9 after A=10 -> no mac_en until B is accepted; res_data=0x5A.
- Wrap: cmd_len=2, pairs (255,255),(1,1) -> res_data=0x02; controller flags nothing.
- Zero length: cmd_len=0 -> one mac_clr, no mac_en, in_ready never 1, res_data=0x00 at cycle 3.
- Backpressure and ignored start: res_ready low for 4 cycles -> res_valid and res_data stable; cmd_start pulsed during RESULT is ignored; busy drops the cycle after res_ready.
- Reset mid-operation: SYS_RST pulse during LOAD_B of pair 2 -> all outputs 0 immediately; a new cmd_len=1 with (3,3) -> res_data=0x09.
